muldiv_hi_lo: RTL and testbench

- Multi-cycle multiply/divide responder owning the architectural HI/LO registers. It serves the EXE-stage hi_lo request interface.
- EXE presents a one-hot hi_lo_op with operands and holds them stable. The block runs the operation and raises hi_lo_ready, then commits HI/LO only when EXE retires the instruction and writes are not disabled.
- Handles MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO and pipeline flush.

---
 rtl/muldiv_hi_lo.sv | 174 +++++++++++++++++
 tb/tb_muldiv_hi_lo.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hi_lo.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | muldiv_hi_lo : multi-cycle MULT/DIV unit that owns the HI/LO registers and   |
// |                answers the EXE-stage hi_lo request interface.               |
// | Revision     : 1.0                                                          |
// +-----------------------------------------------------------------------------+
module muldiv_hi_lo #(
    parameter int MUL_STAGES = 2,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  hi_lo_op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        in_valid,
    input  logic        out_accept,
    input  logic        flush,
    input  logic        wr_disable,
    output logic        hi_lo_ready,
    output logic [31:0] hi_lo_result
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_MUL_LAST = CNT_W'((MUL_STAGES > 1) ? MUL_STAGES - 2 : 0);
    localparam logic [CNT_W-1:0] C_DIV_LAST = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_hi;
    logic [31:0]       r_lo;
    logic [63:0]       r_result;
    logic [31:0]       r_rem;
    logic [31:0]       r_quo;
    logic [31:0]       r_dvs;
    logic [31:0]       r_src1;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_dzero;

    logic        w_is_mul;
    logic        w_is_div;
    logic        w_start_mul;
    logic        w_start_div;
    logic        w_commit;
    logic [63:0] w_a64;
    logic [63:0] w_b64;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_rem_nxt;
    logic [31:0] w_quo_nxt;
    logic [31:0] w_hi_fix;
    logic [31:0] w_lo_fix;

    assign w_is_mul    = hi_lo_op[0] | hi_lo_op[1];
    assign w_is_div    = hi_lo_op[2] | hi_lo_op[3];
    assign w_start_mul = (r_state == ST_IDLE) && in_valid && w_is_mul;
    assign w_start_div = (r_state == ST_IDLE) && in_valid && w_is_div;
    assign w_commit    = hi_lo_ready && out_accept && in_valid && !wr_disable && !flush;

    // Sign/zero extension to 64 bits lets one unsigned multiply serve both MULT and MULTU
    assign w_a64   = {{32{hi_lo_op[0] & src1[31]}}, src1};
    assign w_b64   = {{32{hi_lo_op[0] & src2[31]}}, src2};
    assign w_a_mag = (hi_lo_op[2] && src1[31]) ? (~src1 + 32'd1) : src1;
    assign w_b_mag = (hi_lo_op[2] && src2[31]) ? (~src2 + 32'd1) : src2;

    // One restoring step: shift the next dividend bit into the partial remainder
    assign w_shift   = {r_rem, r_quo[31]};
    assign w_diff    = w_shift - {1'b0, r_dvs};
    assign w_ge      = ~w_diff[32];
    assign w_rem_nxt = w_ge ? w_diff[31:0] : w_shift[31:0];
    assign w_quo_nxt = {r_quo[30:0], w_ge};
    assign w_lo_fix  = r_dzero ? 32'hFFFF_FFFF : (r_neg_q ? (~w_quo_nxt + 32'd1) : w_quo_nxt);
    assign w_hi_fix  = r_dzero ? r_src1 : (r_neg_r ? (~w_rem_nxt + 32'd1) : w_rem_nxt);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        hi_lo_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                hi_lo_ready = !(in_valid && (w_is_mul || w_is_div));
                if (in_valid && w_is_mul) begin
                    w_state_nxt = (MUL_STAGES == 1) ? ST_DONE : ST_MUL;
                end else if (in_valid && w_is_div) begin
                    w_state_nxt = ST_DIV;
                end
            end
            ST_MUL: begin
                if (r_cnt == C_MUL_LAST) w_state_nxt = ST_DONE;
            end
            ST_DIV: begin
                if (r_cnt == C_DIV_LAST) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                hi_lo_ready = 1'b1;
                if (out_accept) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (flush) w_state_nxt = ST_IDLE;
    end

    // Any state change restarts the count, so MUL and DIV both start from zero
    always_ff @(posedge clk) begin
        if (reset || flush || (r_state != w_state_nxt)) begin
            r_cnt <= '0;
        end else if (r_state == ST_MUL || r_state == ST_DIV) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_start_mul) begin
            r_result <= w_a64 * w_b64;
        end
        if (w_start_div) begin
            r_rem   <= '0;
            r_quo   <= w_a_mag;
            r_dvs   <= w_b_mag;
            r_src1  <= src1;
            r_neg_q <= hi_lo_op[2] & (src1[31] ^ src2[31]);
            r_neg_r <= hi_lo_op[2] & src1[31];
            r_dzero <= (src2 == 32'd0);
        end else if (r_state == ST_DIV) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            if (r_cnt == C_DIV_LAST) r_result <= {w_hi_fix, w_lo_fix};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_commit) begin
            if (w_is_mul || w_is_div) begin
                r_hi <= r_result[63:32];
                r_lo <= r_result[31:0];
            end
            if (hi_lo_op[6]) r_hi <= src1;
            if (hi_lo_op[7]) r_lo <= src1;
        end
    end

    always_comb begin
        hi_lo_result = 32'd0;
        if (hi_lo_op[4]) begin
            hi_lo_result = r_hi;
        end else if (hi_lo_op[5]) begin
            hi_lo_result = r_lo;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_hi_lo.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_muldiv_hi_lo : vector table, corner sequences and random ops checked     |
// |                   against an arithmetic HI/LO model.                        |
// | Revision        : 1.0                                                       |
// +-----------------------------------------------------------------------------+
module tb_muldiv_hi_lo;

    localparam int MUL_STAGES = 2;
    localparam int DIV_CYCLES = 32;

    localparam logic [7:0] OP_MULT  = 8'h01;
    localparam logic [7:0] OP_MULTU = 8'h02;
    localparam logic [7:0] OP_DIV   = 8'h04;
    localparam logic [7:0] OP_DIVU  = 8'h08;
    localparam logic [7:0] OP_MFHI  = 8'h10;
    localparam logic [7:0] OP_MFLO  = 8'h20;
    localparam logic [7:0] OP_MTHI  = 8'h40;
    localparam logic [7:0] OP_MTLO  = 8'h80;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  hi_lo_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        in_valid;
    logic        out_accept;
    logic        flush;
    logic        wr_disable;
    logic        hi_lo_ready;
    logic [31:0] hi_lo_result;

    int errors = 0;
    int checks = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          hold;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    muldiv_hi_lo #(
        .MUL_STAGES (MUL_STAGES),
        .DIV_CYCLES (DIV_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .hi_lo_op     (hi_lo_op),
        .src1         (src1),
        .src2         (src2),
        .in_valid     (in_valid),
        .out_accept   (out_accept),
        .flush        (flush),
        .wr_disable   (wr_disable),
        .hi_lo_ready  (hi_lo_ready),
        .hi_lo_result (hi_lo_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void ref_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo);
        logic [63:0] p;
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        hi = 32'd0;
        lo = 32'd0;
        if (op == OP_MULT || op == OP_MULTU) begin
            if (op == OP_MULT) p = longint'(sa) * longint'(sb);
            else               p = {32'd0, a} * {32'd0, b};
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
        end else if (op == OP_DIV) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                lo = 32'h8000_0000;
                hi = 32'd0;
            end else begin
                lo = sa / sb;
                hi = sa % sb;
            end
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endfunction

    // Starts and ends one time unit after a rising edge
    task automatic read_hilo(input string tag);
        hi_lo_op = OP_MFHI; in_valid = 1'b1; out_accept = 1'b1;
        #4;
        chk({tag, " mfhi ready"}, {31'd0, hi_lo_ready}, 32'd1);
        chk({tag, " mfhi"}, hi_lo_result, m_hi);
        @(posedge clk); #1;
        hi_lo_op = OP_MFLO;
        #4;
        chk({tag, " mflo ready"}, {31'd0, hi_lo_ready}, 32'd1);
        chk({tag, " mflo"}, hi_lo_result, m_lo);
        @(posedge clk); #1;
        hi_lo_op = 8'd0; in_valid = 1'b0; out_accept = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit wrdis, input bit fl,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat;
        int exp_lat;
        exp_lat = (op == OP_MULT || op == OP_MULTU) ? MUL_STAGES : DIV_CYCLES + 1;
        hi_lo_op = op; src1 = a; src2 = b; in_valid = 1'b1; out_accept = 1'b0; wr_disable = 1'b0;
        for (lat = 0; lat < 200; lat++) begin
            #4;
            if (hi_lo_ready) break;
            @(posedge clk); #1;
            src1 = ~a;
            src2 = b ^ 32'h5A5A_0001;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #5;
            chk({tag, " ready held"}, {31'd0, hi_lo_ready}, 32'd1);
        end
        out_accept = 1'b1; wr_disable = wrdis; flush = fl;
        @(posedge clk); #1;
        out_accept = 1'b0; wr_disable = 1'b0; flush = 1'b0; hi_lo_op = 8'd0; in_valid = 1'b0;
        if (!wrdis && !fl) begin
            m_hi = exp_hi;
            m_lo = exp_lo;
        end
        read_hilo(tag);
    endtask

    task automatic run_mt(input string tag, input logic [7:0] op, input logic [31:0] d, input bit wrdis);
        hi_lo_op = op; src1 = d; in_valid = 1'b1; out_accept = 1'b1; wr_disable = wrdis;
        #4;
        chk({tag, " ready"}, {31'd0, hi_lo_ready}, 32'd1);
        chk({tag, " result"}, hi_lo_result, 32'd0);
        @(posedge clk); #1;
        hi_lo_op = 8'd0; in_valid = 1'b0; out_accept = 1'b0; wr_disable = 1'b0;
        if (!wrdis) begin
            if (op == OP_MTHI) m_hi = d;
            else               m_lo = d;
        end
        read_hilo(tag);
    endtask

    initial begin
        logic [31:0] rh, rl, ra, rb;
        logic [7:0]  rop;

        vecs[0] = '{OP_MULT,  32'hFFFF_FFFE, 32'd3,        0, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{OP_MULTU, 32'hFFFF_FFFE, 32'd3,        0, 32'h0000_0002, 32'hFFFF_FFFA};
        vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        0, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{OP_DIVU,  32'd7,         32'd0,        0, 32'h0000_0007, 32'hFFFF_FFFF};
        vecs[4] = '{OP_DIVU,  32'd100,       32'd7,        5, 32'd2,         32'd14};
        vecs[5] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0,        32'h8000_0000};
        vecs[6] = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,        0, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[7] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 2, 32'h4000_0000, 32'd0};
        vecs[8] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[9] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 0, 32'd1,        32'hFFFF_FFFD};

        reset = 1'b1; hi_lo_op = 8'd0; src1 = 32'd0; src2 = 32'd0;
        in_valid = 1'b0; out_accept = 1'b0; flush = 1'b0; wr_disable = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #4;
        chk("reset ready", {31'd0, hi_lo_ready}, 32'd1);
        chk("reset result", hi_lo_result, 32'd0);
        @(posedge clk); #1;
        read_hilo("reset");

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hold,
                   1'b0, 1'b0, vecs[i].hi, vecs[i].lo);
        end

        run_mt("mthi wrdis", OP_MTHI, 32'h1234_5678, 1'b1);
        run_mt("mthi", OP_MTHI, 32'h1234_5678, 1'b0);
        run_mt("mtlo", OP_MTLO, 32'hCAFE_F00D, 1'b0);

        // Flush ten iterations into a divide, then a fresh divide right after
        hi_lo_op = OP_DIV; src1 = 32'd100; src2 = 32'd7; in_valid = 1'b1; out_accept = 1'b0;
        repeat (11) @(posedge clk);
        #1 flush = 1'b1;
        #4;
        chk("flush div busy", {31'd0, hi_lo_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        run_op("div after flush", OP_DIV, 32'd9, 32'd3, 0, 1'b0, 1'b0, 32'd0, 32'd3);

        run_op("mult flush at accept", OP_MULT, 32'd5, 32'd7, 0, 1'b0, 1'b1, 32'd0, 32'd35);
        run_op("divu wrdis", OP_DIVU, 32'd50, 32'd3, 1, 1'b1, 1'b0, 32'd2, 32'd16);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
            case ($urandom_range(0, 5))
                0: rop = OP_MULT;
                1: rop = OP_MULTU;
                2: rop = OP_DIV;
                3: rop = OP_DIVU;
                4: rop = OP_MTHI;
                default: rop = OP_MTLO;
            endcase
            if (rop == OP_MTHI || rop == OP_MTLO) begin
                run_mt($sformatf("rnd%0d mt", i), rop, ra, ($urandom_range(0, 4) == 0));
            end else begin
                ref_op(rop, ra, rb, rh, rl);
                run_op($sformatf("rnd%0d op%h", i, rop), rop, ra, rb, $urandom_range(0, 2),
                       ($urandom_range(0, 4) == 0), 1'b0, rh, rl);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
